// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - Q11.20 fixed-point types and envelope state encoding
package fixed_point_pkg;

   localparam int FRAC_BITS = 20;

   typedef logic signed [31:0] fixed_t;
   typedef logic signed [32:0] wide_t;

   localparam fixed_t ONE = 32'sd1 <<< FRAC_BITS;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_t;

   function automatic wide_t to_wide(input fixed_t x);
      return {x[31], x};
   endfunction

   // Negative rates are treated as "no movement".
   function automatic wide_t rate_wide(input fixed_t x);
      return x[31] ? '0 : {1'b0, x};
   endfunction

endpackage

// File: rtl/envelope_step.sv
// rtl/envelope_step.sv - per-tick next stage and level, computed at 33 bits and clamped to [0, ONE]
module envelope_step
   import fixed_point_pkg::*;
#(
   parameter int FRAC_BITS = fixed_point_pkg::FRAC_BITS
) (
   input  env_state_t state_i,
   input  fixed_t     level_i,
   input  logic       gate_i,
   input  logic       gate_rise_i,
   input  fixed_t     attack_step_i,
   input  fixed_t     decay_step_i,
   input  fixed_t     sustain_level_i,
   input  fixed_t     release_step_i,
   output env_state_t state_o,
   output fixed_t     level_o
);

   localparam wide_t ONE_W = 33'sd1 <<< FRAC_BITS;

   wide_t level_w;
   wide_t sustain_w;
   wide_t sustain_clamped;
   wide_t attack_sum;
   wide_t decay_diff;
   wide_t release_diff;
   wide_t next_w;

   always_comb begin
      level_w      = to_wide(level_i);
      sustain_w    = to_wide(sustain_level_i);
      attack_sum   = level_w + rate_wide(attack_step_i);
      decay_diff   = level_w - rate_wide(decay_step_i);
      release_diff = level_w - rate_wide(release_step_i);

      if (sustain_w < 0)
         sustain_clamped = '0;
      else if (sustain_w > ONE_W)
         sustain_clamped = ONE_W;
      else
         sustain_clamped = sustain_w;
   end

   always_comb begin
      state_o = state_i;
      next_w  = level_w;

      if (gate_rise_i || (state_i == ST_ATTACK && gate_i)) begin
         // A retrigger keeps the current level and ramps up from it.
         if (attack_sum >= ONE_W) begin
            next_w  = ONE_W;
            state_o = ST_DECAY;
         end else begin
            next_w  = attack_sum;
            state_o = ST_ATTACK;
         end
      end else if (state_i == ST_RELEASE ||
                   (!gate_i && (state_i == ST_ATTACK || state_i == ST_DECAY ||
                                state_i == ST_SUSTAIN))) begin
         if (release_diff <= 0) begin
            next_w  = '0;
            state_o = ST_IDLE;
         end else begin
            next_w  = release_diff;
            state_o = ST_RELEASE;
         end
      end else begin
         case (state_i)
            ST_DECAY: begin
               if (decay_diff <= sustain_clamped) begin
                  next_w  = sustain_clamped;
                  state_o = ST_SUSTAIN;
               end else begin
                  next_w  = decay_diff;
               end
            end
            ST_SUSTAIN: next_w = sustain_clamped;
            default: begin
               next_w  = '0;
               state_o = ST_IDLE;
            end
         endcase
      end

      level_o = next_w[31:0];
   end

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - ADSR gain envelope: stage register, gate edge detect and registered outputs
module adsr_envelope
   import fixed_point_pkg::*;
#(
   parameter int FRAC_BITS = 20
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               sample_tick,
   input  logic               gate,
   input  logic signed [31:0] attack_step,
   input  logic signed [31:0] decay_step,
   input  logic signed [31:0] sustain_level,
   input  logic signed [31:0] release_step,
   output logic signed [31:0] level,
   output logic               level_valid,
   output logic [2:0]         stage,
   output logic               active
);

   env_state_t state_q, state_d, step_state;
   fixed_t     level_q, level_d, step_level;
   logic       prev_gate_q, prev_gate_d;
   logic       valid_q, valid_d;

   envelope_step #(
      .FRAC_BITS(FRAC_BITS)
   ) u_step (
      .state_i        (state_q),
      .level_i        (level_q),
      .gate_i         (gate),
      .gate_rise_i    (gate && !prev_gate_q),
      .attack_step_i  (attack_step),
      .decay_step_i   (decay_step),
      .sustain_level_i(sustain_level),
      .release_step_i (release_step),
      .state_o        (step_state),
      .level_o        (step_level)
   );

   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      prev_gate_d = prev_gate_q;
      valid_d     = 1'b0;
      if (sample_tick) begin
         state_d     = step_state;
         level_d     = step_level;
         prev_gate_d = gate;
         valid_d     = 1'b1;
      end
   end

   // prev_gate clears on reset so the first gated tick afterwards is a rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         level_q     <= '0;
         prev_gate_q <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         prev_gate_q <= prev_gate_d;
         valid_q     <= valid_d;
      end
   end

   assign level       = level_q;
   assign level_valid = valid_q;
   assign stage       = state_q;
   assign active      = (state_q != ST_IDLE);

endmodule
